aha_simple_if_to_axi: RTL

Bridge from the Simple Interface request side to a single-beat AXI4 master, used where a Simple-Interface-style agent (e.g. a CGRA-side DMA or config engine) must initiate transactions onto the SoC AXI interconnect. It is the initiator counterpart of the AXI-to-Simple-Interface slave bridge. It accepts one 64-bit read or write request at a time, drives the matching AXI4 channel handshakes, and returns read data and response status on the Simple Interface side.

---
 rtl/aha_axi_pkg.sv | 31 +++
 rtl/aha_simple_if_to_axi_if.sv | 75 +++++++
 rtl/aha_simple_if_to_axi.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/aha_axi_pkg.sv
// Shared AXI4 encodings and the bridge state enum for the Simple Interface
// to AXI4 master bridge.
//   BURST_INCR                          : AxBURST encoding for INCR bursts
//   RESP_OKAY/RESP_SLVERR/RESP_DECERR   : xRESP encodings
//   SIZE_64B                            : AxSIZE for 8-byte beats
//   CACHE_BUF_MOD                       : AxCACHE bufferable + modifiable
//   bridge_state_t                      : request FSM states
//   resp_is_err()                       : true for SLVERR/DECERR
package aha_axi_pkg;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] RESP_DECERR   = 2'b11;
  localparam logic [2:0] SIZE_64B      = 3'b011;
  localparam logic [3:0] CACHE_BUF_MOD = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA
  } bridge_state_t;

  // Both error encodings have bit 1 set; EXOKAY is not an error here.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/aha_simple_if_to_axi_if.sv
// AXI4 single-beat bus bundle between the bridge (master) and the SoC
// interconnect (slave).
//   master modport : drives AW/W/AR payload and VALIDs, BREADY, RREADY
//   slave  modport : drives AWREADY/WREADY/ARREADY and the B/R channels
interface aha_simple_if_to_axi_if #(
  parameter int ID_WIDTH = 4
) ();

  logic [ID_WIDTH-1:0] AWID;
  logic [31:0]         AWADDR;
  logic [7:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWLOCK;
  logic [3:0]          AWCACHE;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;

  logic [63:0]         WDATA;
  logic [7:0]          WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;

  logic [ID_WIDTH-1:0] BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  logic [ID_WIDTH-1:0] ARID;
  logic [31:0]         ARADDR;
  logic [7:0]          ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARLOCK;
  logic [3:0]          ARCACHE;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;

  logic [ID_WIDTH-1:0] RID;
  logic [63:0]         RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

endinterface

// File: rtl/aha_simple_if_to_axi.sv
// Simple Interface request side to single-beat AXI4 master bridge.
// One 64-bit read or write is in flight at a time.
//   ACLK, ARESETn        : clock, asynchronous active-low reset
//   SIF_REQ/SIF_WR       : request strobe (sampled while idle) and direction
//   SIF_ADDR/WSTRB/WDATA : request payload, captured at acceptance
//   SIF_BUSY             : bridge not idle
//   SIF_DONE/SIF_ERR     : one-cycle completion pulse with error flag
//   SIF_RD_DATA          : last read data, held until the next read completes
//   axi                  : AXI4 master port (AW/W/B/AR/R)
module aha_simple_if_to_axi
  import aha_axi_pkg::*;
#(
  parameter int          ID_WIDTH = 4,
  parameter int unsigned TXN_ID   = 0
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        SIF_REQ,
  input  logic        SIF_WR,
  input  logic [31:0] SIF_ADDR,
  input  logic [7:0]  SIF_WSTRB,
  input  logic [63:0] SIF_WDATA,
  output logic        SIF_BUSY,
  output logic        SIF_DONE,
  output logic        SIF_ERR,
  output logic [63:0] SIF_RD_DATA,
  aha_simple_if_to_axi_if.master axi
);

  localparam logic [ID_WIDTH-1:0] ID_C = ID_WIDTH'(TXN_ID);

  bridge_state_t state;
  logic          aw_done, w_done;
  logic          awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic [31:0]   addr_q;
  logic [63:0]   wdata_q;
  logic [7:0]    wstrb_q;

  logic accept, aw_hs, w_hs, aw_done_nx, w_done_nx;

  // The beat is always 8-byte aligned, so the low address bits are dropped.
  logic unused_addr_lo;
  assign unused_addr_lo = ^SIF_ADDR[2:0];

  assign accept     = (state == ST_IDLE) && SIF_REQ;
  assign aw_hs      = awvalid_q && axi.AWREADY;
  assign w_hs       = wvalid_q && axi.WREADY;
  // Including this cycle's handshakes lets a same-cycle AW+W completion
  // move straight to the response phase.
  assign aw_done_nx = aw_done || aw_hs;
  assign w_done_nx  = w_done || w_hs;

  // Acceptance: payload is captured once and held for the whole transaction.
  always_ff @(posedge ACLK) begin
    if (accept) begin
      addr_q  <= {SIF_ADDR[31:3], 3'b000};
      wdata_q <= SIF_WDATA;
      wstrb_q <= SIF_WSTRB;
    end
  end

  // Request FSM with all handshake and status outputs registered.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= ST_IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      SIF_BUSY    <= 1'b0;
      SIF_DONE    <= 1'b0;
      SIF_ERR     <= 1'b0;
      SIF_RD_DATA <= '0;
    end else begin
      SIF_DONE <= 1'b0;
      SIF_ERR  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (SIF_REQ) begin
            SIF_BUSY <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            if (SIF_WR) begin
              state     <= ST_WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state     <= ST_RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (aw_hs) begin
            aw_done   <= 1'b1;
            awvalid_q <= 1'b0;
          end
          if (w_hs) begin
            w_done   <= 1'b1;
            wvalid_q <= 1'b0;
          end
          if (aw_done_nx && w_done_nx) begin
            state    <= ST_WR_RESP;
            bready_q <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (axi.BVALID) begin
            state    <= ST_IDLE;
            bready_q <= 1'b0;
            SIF_BUSY <= 1'b0;
            SIF_DONE <= 1'b1;
            SIF_ERR  <= resp_is_err(axi.BRESP) || (axi.BID != ID_C);
          end
        end
        ST_RD_ADDR: begin
          if (axi.ARREADY) begin
            state     <= ST_RD_DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (axi.RVALID) begin
            state       <= ST_IDLE;
            rready_q    <= 1'b0;
            SIF_BUSY    <= 1'b0;
            SIF_DONE    <= 1'b1;
            SIF_RD_DATA <= axi.RDATA;
            SIF_ERR     <= resp_is_err(axi.RRESP) || !axi.RLAST || (axi.RID != ID_C);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign axi.AWID    = ID_C;
  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = 8'd0;
  assign axi.AWSIZE  = SIZE_64B;
  assign axi.AWBURST = BURST_INCR;
  assign axi.AWLOCK  = 1'b0;
  assign axi.AWCACHE = CACHE_BUF_MOD;
  assign axi.AWPROT  = 3'b000;
  assign axi.AWVALID = awvalid_q;

  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WLAST   = 1'b1;
  assign axi.WVALID  = wvalid_q;

  assign axi.BREADY  = bready_q;

  assign axi.ARID    = ID_C;
  assign axi.ARADDR  = addr_q;
  assign axi.ARLEN   = 8'd0;
  assign axi.ARSIZE  = SIZE_64B;
  assign axi.ARBURST = BURST_INCR;
  assign axi.ARLOCK  = 1'b0;
  assign axi.ARCACHE = CACHE_BUF_MOD;
  assign axi.ARPROT  = 3'b000;
  assign axi.ARVALID = arvalid_q;

  assign axi.RREADY  = rready_q;

endmodule
